// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: register write port, request channel and operand-pair channel.
interface operand_fetch_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_rs1;
  logic [ADDR_W-1:0] req_rs2;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [CNT_W-1:0]  issue_cnt;

  // Producer / consumer side (drives writes and requests, absorbs operand pairs)
  modport master (
    output wr_en, wr_addr, wr_data,
    output req_valid, req_rs1, req_rs2,
    output op_ready,
    input  req_ready, op_valid, op_a, op_b, issue_cnt
  );

  // Operand-fetch stage side
  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  req_valid, req_rs1, req_rs2,
    input  op_ready,
    output req_ready, op_valid, op_a, op_b, issue_cnt
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file with write bypass feeding a one-deep
// registered operand-pair buffer toward the adder.
module operand_fetch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  operand_fetch_if.slave bus
);
  localparam int unsigned NREGS = 1 << ADDR_W;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              op_valid;
  logic              ready;
  logic              accept;
  logic              consume;
  logic [DATA_W-1:0] src_a, src_b;

  assign op_valid = (state_q == ST_FULL);
  assign ready    = !op_valid || bus.op_ready;
  assign accept   = bus.req_valid && ready;
  assign consume  = op_valid && bus.op_ready;

  // Write-to-read bypass so a result written this cycle is fetched immediately
  always_comb begin
    src_a = rf[bus.req_rs1];
    src_b = rf[bus.req_rs2];
    if (bus.wr_en && (bus.wr_addr == bus.req_rs1)) src_a = bus.wr_data;
    if (bus.wr_en && (bus.wr_addr == bus.req_rs2)) src_b = bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && bus.op_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (bus.wr_en) begin
      rf[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Operands load only on accept; a stalled pair is never refreshed by writes
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (accept) begin
      op_a_q <= src_a;
      op_b_q <= src_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          cnt_q <= '0;
    else if (consume) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.req_ready = ready;
  assign bus.op_valid  = op_valid;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.issue_cnt = cnt_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with an expected-pair scoreboard.
module tb_operand_fetch;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pair_t             sb_q[$];
  logic [DATA_W-1:0] m_rf [8];
  logic              m_valid;
  logic [CNT_W-1:0]  m_cnt;
  logic [CNT_W-1:0]  cnt_start;

  operand_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] src(input logic [ADDR_W-1:0] i);
    if (bus.wr_en && bus.wr_addr == i) return bus.wr_data;
    return m_rf[i];
  endfunction

  // One clock: check handshake/outputs against the model, then advance model and DUT
  task automatic tick();
    logic  rdy, acc, con;
    pair_t exp;
    #1;
    rdy = !m_valid || bus.op_ready;
    acc = bus.req_valid && rdy;
    con = m_valid && bus.op_ready;
    chk("op_valid", 64'(bus.op_valid), 64'(m_valid));
    chk("req_ready", 64'(bus.req_ready), 64'(rdy));
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 64'(0), 64'(1));
      end else begin
        chk("op_a", 64'(bus.op_a), 64'(sb_q[0].a));
        chk("op_b", 64'(bus.op_b), 64'(sb_q[0].b));
      end
    end
    if (rst) begin
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      sb_q.delete();
      m_valid = 1'b0;
      m_cnt   = '0;
    end else begin
      if (con && sb_q.size() > 0) void'(sb_q.pop_front());
      if (acc) begin
        exp.a = src(bus.req_rs1);
        exp.b = src(bus.req_rs2);
        sb_q.push_back(exp);
        m_valid = 1'b1;
      end else if (con) begin
        m_valid = 1'b0;
      end
      if (con) m_cnt = m_cnt + CNT_W'(1);
      if (bus.wr_en) m_rf[bus.wr_addr] = bus.wr_data;
    end
    @(posedge clk);
    #1;
    chk("issue_cnt", 64'(bus.issue_cnt), 64'(m_cnt));
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.req_valid = 1'b0; bus.op_ready = 1'b1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
  endtask

  task automatic req(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    bus.req_valid = 1'b1; bus.req_rs1 = r1; bus.req_rs2 = r2;
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_addr = '0; bus.wr_data = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
    idle();
    for (int i = 0; i < 8; i++) m_rf[i] = 'x;
    m_valid = 1'b0;
    m_cnt   = '0;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    chk("rst_op_valid", 64'(bus.op_valid), 64'(0));
    chk("rst_op_a", 64'(bus.op_a), 64'(0));
    chk("rst_op_b", 64'(bus.op_b), 64'(0));
    chk("rst_cnt", 64'(bus.issue_cnt), 64'(0));
    chk("rst_ready", 64'(bus.req_ready), 64'(1));

    // Basic fetch and adder sum
    wr(3'd0, 32'hDEADBEEF); tick();
    wr(3'd1, 32'hBEEFDEAD); tick();
    idle(); req(3'd0, 3'd1); tick();
    idle();
    chk("t1_valid", 64'(bus.op_valid), 64'(1));
    chk("t1_a", 64'(bus.op_a), 64'h0DEADBEEF);
    chk("t1_b", 64'(bus.op_b), 64'h0BEEFDEAD);
    chk("t1_sum", 64'(33'(bus.op_a) + 33'(bus.op_b)), 64'h1_9D9D_9D9C);
    tick();

    // Same-cycle write bypass
    wr(3'd3, 32'h00000001); tick();
    idle(); wr(3'd2, 32'hFFFFFFFF); req(3'd2, 3'd3); tick();
    idle();
    chk("t2_a", 64'(bus.op_a), 64'h0FFFFFFFF);
    chk("t2_b", 64'(bus.op_b), 64'h000000001);
    chk("t2_sum", 64'(33'(bus.op_a) + 33'(bus.op_b)), 64'h1_0000_0000);
    tick();

    // Backpressure with a write to the held source register
    req(3'd0, 3'd1); bus.op_ready = 1'b0; tick();
    cnt_start = bus.issue_cnt;
    bus.req_valid = 1'b0; wr(3'd0, 32'h0); tick();
    bus.wr_en = 1'b0; req(3'd2, 3'd2); tick();
    tick();
    chk("t3_ready", 64'(bus.req_ready), 64'(0));
    chk("t3_hold_a", 64'(bus.op_a), 64'h0DEADBEEF);
    idle(); tick();
    chk("t3_cnt", 64'(bus.issue_cnt - cnt_start), 64'(1));

    // Streaming four pairs, no bubbles
    cnt_start = bus.issue_cnt;
    idle(); req(3'd0, 3'd1); tick();
    req(3'd1, 3'd0); tick();
    chk("t4_valid1", 64'(bus.op_valid), 64'(1));
    req(3'd2, 3'd2); tick();
    chk("t4_valid2", 64'(bus.op_valid), 64'(1));
    req(3'd3, 3'd1); tick();
    chk("t4_valid3", 64'(bus.op_valid), 64'(1));
    idle(); tick();
    chk("t4_cnt", 64'(bus.issue_cnt - cnt_start), 64'(4));

    // Reset while stalled; rst overrides write, request and consume
    req(3'd1, 3'd2); bus.op_ready = 1'b0; tick();
    rst = 1'b1; wr(3'd4, 32'h12345678); bus.op_ready = 1'b1; tick();
    rst = 1'b0; idle();
    chk("t5_valid", 64'(bus.op_valid), 64'(0));
    chk("t5_a", 64'(bus.op_a), 64'(0));
    chk("t5_b", 64'(bus.op_b), 64'(0));
    chk("t5_cnt", 64'(bus.issue_cnt), 64'(0));
    for (int i = 0; i < 8; i += 2) begin
      req(3'(i), 3'(i + 1)); tick();
    end
    idle(); tick();

    // Counter wrap after 16 consumes, random traffic with random writes
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'($urandom_range(0, 1));
      bus.wr_addr = 3'($urandom_range(0, 7));
      bus.wr_data = $urandom;
      req(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      tick();
    end
    idle();
    chk("t6_cnt15", 64'(bus.issue_cnt), 64'(15));
    tick();
    chk("t6_wrap", 64'(bus.issue_cnt), 64'(0));
    chk("t6_empty", 64'(bus.op_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
